// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad decoder: key codes, press FSM states,
// and the classification of one scanner sample.
package keypad_pkg;

    localparam int unsigned KEY_W  = 12;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] KEY_STAR = 4'hA;
    localparam logic [CODE_W-1:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DEB,
        ST_HELD,
        ST_REL_DEB
    } key_state_e;

    typedef struct packed {
        logic              valid;
        logic              multi;
        logic [CODE_W-1:0] code;
    } key_class_t;

    // Bits 0..8 are keys 1..9, bit 9 is '*', bit 10 is '0', bit 11 is '#'.
    function automatic key_class_t onehot_to_code(input logic [KEY_W-1:0] bits);
        key_class_t        r;
        int unsigned       ones;
        logic [CODE_W-1:0] c;
        ones = 0;
        c    = '0;
        for (int i = 0; i < int'(KEY_W); i++) begin
            if (bits[i]) begin
                ones = ones + 1;
                if (i < 9)       c = CODE_W'(i + 1);
                else if (i == 9) c = KEY_STAR;
                else if (i == 10) c = '0;
                else             c = KEY_HASH;
            end
        end
        r.valid = (ones == 1);
        r.multi = (ones > 1);
        r.code  = (ones == 1) ? c : '0;
        return r;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Valid/ready stream carrying decoded key codes to the downstream consumer.
interface keypad_if;
    import keypad_pkg::*;

    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              out_ready;

    modport master (output out_valid, output out_code, input out_ready);
    modport slave  (input out_valid, input out_code, output out_ready);
endinterface

// File: rtl/keypad_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module keypad_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/keypad_decoder.sv
// Turns the one-hot keypad scanner bus into debounced, single-shot key events
// queued in a FIFO and delivered over a valid/ready stream.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 25000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_data,
    keypad_if.master          bus,
    output logic              key_held,
    output logic [CODE_W-1:0] key_cur,
    output logic              err_multi,
    output logic              err_ovf
);
    localparam int unsigned PW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W = 4;

    logic [PW-1:0]     pcnt;
    logic              tick;
    logic [KEY_W-1:0]  samp;
    key_class_t        cls;

    key_state_e        state, state_nxt;
    logic [CODE_W-1:0] cand, cand_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic              push_c;
    logic              held_nxt;
    logic [CODE_W-1:0] cur_nxt;
    logic              push_q;
    logic [CODE_W-1:0] push_code_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CODE_W-1:0] fifo_head;
    logic              pop;
    logic              ovf_c;

    assign tick = (pcnt == PW'(SAMPLE_DIV - 1));
    assign cls  = onehot_to_code(samp);

    // Prescaler and sample register; the FSM always sees the previous tick's sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            samp <= '0;
        end else if (tick) begin
            pcnt <= '0;
            samp <= key_data;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (cls.valid) begin
                        cand_nxt  = cls.code;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_PRESS_DEB;
                    end
                end
                ST_PRESS_DEB: begin
                    if (!cls.valid) begin
                        state_nxt = ST_IDLE;
                    end else if (cls.code == cand) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt_nxt == CNT_W'(DEBOUNCE_CNT)) state_nxt = ST_HELD;
                    end else begin
                        cand_nxt = cls.code;
                        cnt_nxt  = CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!(cls.valid && cls.code == cand)) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_REL_DEB;
                    end
                end
                ST_REL_DEB: begin
                    if (cls.valid && cls.code == cand) begin
                        state_nxt = ST_HELD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt_nxt == CNT_W'(DEBOUNCE_CNT)) state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Only the PRESS_DEB -> HELD transition produces an event; re-entry from REL_DEB does not.
    always_comb begin
        push_c   = 1'b0;
        held_nxt = 1'b0;
        cur_nxt  = '0;
        push_c   = tick && (state == ST_PRESS_DEB) && (state_nxt == ST_HELD);
        held_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_REL_DEB);
        if (held_nxt) cur_nxt = cand_nxt;
    end

    assign pop   = bus.out_ready && !fifo_empty;
    assign ovf_c = push_q && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_held    <= 1'b0;
            key_cur     <= '0;
            err_multi   <= 1'b0;
            err_ovf     <= 1'b0;
            push_q      <= 1'b0;
            push_code_q <= '0;
        end else begin
            key_held    <= held_nxt;
            key_cur     <= cur_nxt;
            err_multi   <= err_multi | (tick & cls.multi);
            err_ovf     <= err_ovf | ovf_c;
            push_q      <= push_c;
            push_code_q <= cand;
        end
    end

    keypad_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_code_q),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_code  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench: directed keypad scenarios plus random traffic, compared
// every cycle against a run-length debounce model with a queue for the FIFO.
module tb_keypad_decoder;
    import keypad_pkg::*;

    localparam int unsigned SDIV  = 2;
    localparam int unsigned DEB   = 3;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] key_data = '0;
    logic        key_held;
    logic [3:0]  key_cur;
    logic        err_multi;
    logic        err_ovf;

    keypad_if bus();

    keypad_decoder #(
        .SAMPLE_DIV   (SDIV),
        .DEBOUNCE_CNT (DEB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_data  (key_data),
        .bus       (bus),
        .key_held  (key_held),
        .key_cur   (key_cur),
        .err_multi (err_multi),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          code_of [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int          m_pc = 0;
    logic [11:0] m_samp = '0;
    bit          m_held = 0;
    int          m_hkey = 0;
    int          m_skey = 0;
    int          m_streak = 0;
    bit          m_pend = 0;
    int          m_pcode = 0;
    bit          m_emulti = 0;
    bit          m_eovf = 0;
    int          q[$];
    int          mlog[$];
    int          dlog[$];

    task automatic process_sample(input logic [11:0] s);
        int c;
        c = -1;
        if ($countones(s) > 1) m_emulti = 1;
        if ($countones(s) == 1)
            for (int i = 0; i < 12; i++) if (s[i]) c = code_of[i];
        if (!m_held) begin
            if (c < 0) m_streak = 0;
            else if (m_streak > 0 && c == m_skey) m_streak++;
            else begin m_skey = c; m_streak = 1; end
            if (m_streak == int'(DEB)) begin
                m_pend = 1; m_pcode = m_skey;
                m_held = 1; m_hkey = m_skey; m_streak = 0;
            end
        end else begin
            if (c == m_hkey) m_streak = 0;
            else m_streak++;
            if (m_streak == int'(DEB)) begin m_held = 0; m_streak = 0; end
        end
    endtask

    task automatic model_step();
        int  pre;
        bit  popping;
        bit  pend;
        if (rst) begin
            m_pc = 0; m_samp = '0; m_held = 0; m_hkey = 0; m_skey = 0; m_streak = 0;
            m_pend = 0; m_emulti = 0; m_eovf = 0; q.delete();
        end else begin
            pre     = q.size();
            popping = (pre > 0) && bus.out_ready;
            pend    = m_pend;
            m_pend  = 0;
            if (popping) mlog.push_back(q.pop_front());
            if (pend) begin
                if (pre == int'(DEPTH) && !popping) m_eovf = 1;
                else q.push_back(m_pcode);
            end
            if (m_pc == int'(SDIV) - 1) begin
                process_sample(m_samp);
                m_samp = key_data;
                m_pc = 0;
            end else begin
                m_pc++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("out_valid", int'(bus.out_valid), (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) check("out_code", int'(bus.out_code), q[0]);
        check("key_held", int'(key_held), int'(m_held));
        check("key_cur", int'(key_cur), m_held ? m_hkey : 0);
        check("err_multi", int'(err_multi), int'(m_emulti));
        check("err_ovf", int'(err_ovf), int'(m_eovf));
        if (bus.out_valid && bus.out_ready) dlog.push_back(int'(bus.out_code));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [11:0] v, input int ticks);
        key_data = v;
        cycles(ticks * int'(SDIV));
    endtask

    task automatic press(input int b);
        hold(12'(1) << b, 5);
        hold('0, 5);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        dlog.delete();
        mlog.delete();
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " out_valid"}, int'(bus.out_valid), 0);
        check({nm, " out_code"}, int'(bus.out_code), 0);
        check({nm, " key_held"}, int'(key_held), 0);
        check({nm, " key_cur"}, int'(key_cur), 0);
        check({nm, " err_multi"}, int'(err_multi), 0);
        check({nm, " err_ovf"}, int'(err_ovf), 0);
    endtask

    task automatic check_log(input string nm, input int n, input logic [31:0] v);
        check($sformatf("%s dut events", nm), dlog.size(), n);
        check($sformatf("%s model events", nm), mlog.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s dut[%0d]", nm, i), (i < dlog.size()) ? dlog[i] : -1, int'(v[4*i +: 4]));
            check($sformatf("%s model[%0d]", nm, i), (i < mlog.size()) ? mlog[i] : -1, int'(v[4*i +: 4]));
        end
    endtask

    int first_valid;
    int dur;

    initial begin
        bus.out_ready = 1'b0;
        do_reset();
        check_reset_outputs("reset");

        // Single press of key 5.
        bus.out_ready = 1'b1;
        key_data = 12'h010;
        cycles(12);
        check("single key_held", int'(key_held), 1);
        check("single key_cur", int'(key_cur), 5);
        cycles(8);
        hold('0, 6);
        check("single released", int'(key_held), 0);
        check_log("single", 1, 32'h5);

        // Bounce on '*': out_valid first seen 2*DEB+3 cycles after the stable run starts.
        do_reset();
        bus.out_ready = 1'b1;
        hold(12'h200, 1);
        hold('0, 1);
        key_data = 12'h200;
        first_valid = -1;
        for (int i = 1; i <= 10; i++) begin
            cycles(1);
            if (first_valid < 0 && bus.out_valid) first_valid = i;
        end
        check("bounce latency", first_valid, 9);
        hold('0, 6);
        check_log("bounce", 1, 32'hA);

        // Short release glitch on '#'.
        do_reset();
        bus.out_ready = 1'b1;
        hold(12'h800, 6);
        hold('0, 2);
        hold(12'h800, 5);
        hold('0, 6);
        check_log("glitch", 1, 32'hB);

        // Overflow: fifth press dropped.
        do_reset();
        bus.out_ready = 1'b0;
        press(0); press(1); press(2); press(3); press(10);
        check("ovf err_ovf", int'(err_ovf), 1);
        check("ovf head", int'(bus.out_code), 1);
        bus.out_ready = 1'b1;
        cycles(10);
        bus.out_ready = 1'b0;
        check_log("ovf", 4, 32'h4321);

        // Full FIFO with a pop in exactly the cycle the fifth code is pushed.
        do_reset();
        bus.out_ready = 1'b0;
        press(0); press(1); press(2); press(3);
        key_data = 12'h010;
        cycles(8);
        bus.out_ready = 1'b1;
        cycles(1);
        bus.out_ready = 1'b0;
        cycles(1);
        hold('0, 5);
        check("fullpop err_ovf", int'(err_ovf), 0);
        bus.out_ready = 1'b1;
        cycles(12);
        check_log("fullpop", 5, 32'h54321);

        // Multi-key sample, then reset in the middle of a key-7 press.
        do_reset();
        bus.out_ready = 1'b1;
        hold(12'h003, 5);
        hold('0, 2);
        check("multi err_multi", int'(err_multi), 1);
        check_log("multi", 0, 32'h0);
        hold(12'h040, 2);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        check_reset_outputs("midreset");
        dlog.delete();
        mlog.delete();
        hold(12'h040, 3);
        hold('0, 6);
        check_log("midreset", 1, 32'h7);

        // Random traffic with occasional resets.
        do_reset();
        dur = 0;
        for (int c = 0; c < 4000; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (dur == 0) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 30)      key_data = '0;
                else if (r < 88) key_data = 12'(1) << $urandom_range(0, 11);
                else             key_data = 12'($urandom);
                dur = int'($urandom_range(1, 16));
            end
            dur--;
            rst = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        rst = 1'b0;
        key_data = '0;
        bus.out_ready = 1'b1;
        cycles(40);
        check("final drained", int'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Consumes the 12-bit one-hot `key_data` bus from the 4x3 keypad scanner and turns it into debounced, de-duplicated key events. Each press produces exactly one 4-bit key code, regardless of how long the key is held. Codes are queued in a small FIFO and delivered over a valid/ready handshake to the downstream control logic (menu/entry FSMs). The block runs on the system clock and samples the scanner output at the scanner's column rate.

## Interface
- `SAMPLE_DIV`, default 25000: system-clock cycles per sample tick. Matches the scanner's scan-clock period.
- `DEBOUNCE_CNT`, default 4: number of consecutive identical samples required to accept a press or a release. Legal range 2..15.
- `FIFO_DEPTH`, default 4: depth of the event queue. Must be a power of 2, at least 2.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `key_data` in 12: one-hot key bus from the scanner.
  - bit0..bit8 = keys 1..9
  - bit9 = `*`
  - bit10 = `0`
  - bit11 = `#`
- `out_valid` out 1: FIFO not empty.
- `out_code` out 4: code at the FIFO head. Codes are 0x0..0x9 for digits, 0xA for `*`, 0xB for `#`.
- `out_ready` in 1: consumer accepts the head code when `out_valid && out_ready`.
- `key_held` out 1: a debounced key is currently down (state HELD or REL_DEB).
- `key_cur` out 4: code of the held key. 0x0 when `key_held` = 0.
- `err_multi` out 1: sticky. Set when a sample has more than one bit set.
- `err_ovf` out 1: sticky. Set when an accepted press is dropped because the FIFO is full.

## Operation
- **Sample tick:** a prescaler counts 0..SAMPLE_DIV-1 and pulses `tick` for one cycle at SAMPLE_DIV-1. On `tick`, `key_data` is registered into `samp`.
- **Sample classification:** all logic acts on `samp`, one tick after it is captured.
  - zero = NONE
  - exactly one bit set = KEY(code)
  - two or more bits set = NONE, and sets `err_multi`
- **Press FSM:** state changes only on ticks. States are IDLE, PRESS_DEB, HELD, REL_DEB.
  - IDLE: KEY(c) → `cand` = c, `cnt` = 1, go to PRESS_DEB.
  - PRESS_DEB:
    - KEY(`cand`) → `cnt`++. When `cnt` reaches DEBOUNCE_CNT, push `cand` and go to HELD.
    - KEY(other) → `cand` = other, `cnt` = 1.
    - NONE → IDLE.
  - HELD: any sample other than KEY(`cand`) → `cnt` = 1, go to REL_DEB.
  - REL_DEB:
    - KEY(`cand`) → back to HELD. No new event is produced.
    - Otherwise `cnt`++. When `cnt` reaches DEBOUNCE_CNT, go to IDLE.
    - A different key held throughout REL_DEB is treated as a release of `cand`. It is then re-detected from IDLE starting at the next tick.
- **Rollover:** a second key pressed while the first is held produces no event until the first is released.
- **FIFO:** circular buffer with read/write pointers one bit wider than the address, so full and empty are distinguishable.
  - Push while full is dropped and sets `err_ovf`. Existing contents are unchanged.
  - Pop while empty has no effect.
  - Push and pop in the same cycle while full: both are performed. The element count is unchanged and the pushed code is not dropped.
  - Push and pop in the same cycle while empty: only the push takes effect.
- **`out_code`:** holds the head value while `out_valid` = 1 and `out_ready` = 0. Its value while `out_valid` = 0 is don't-care.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_code` = 0, `key_held` = 0, `key_cur` = 0, `err_multi` = 0, `err_ovf` = 0
  - FSM = IDLE, prescaler = 0, `samp` = 0, FIFO pointers = 0
- **Reset mid-operation:** discards the FIFO contents and any press in progress. A key still held after reset is re-debounced from IDLE and produces one new event.
- **Press latency:** if a key is first captured into `samp` on tick T and stays stable, the push happens on tick T+DEBOUNCE_CNT. `out_valid` rises on the following clock edge, one cycle after the push.
- **Release:** `key_held` falls on the tick that enters IDLE.
- **`key_held` and `key_cur`:** both are registered and update on the same edge as the state change.
- **Error flags:** sticky until `rst`.

## Structure
- **Package `keypad_pkg`:**
  - key code constants: `KEY_STAR` = 4'hA, `KEY_HASH` = 4'hB
  - FSM state enum
  - function `onehot_to_code(12b) → {valid, multi, code[3:0]}`
- **Sub-module `keypad_fifo`:** generic synchronous FIFO with parameters WIDTH and DEPTH. It exposes push, pop, full, empty and head data, and is reusable elsewhere in the design.
- The prescaler, sample register and FSM live in `keypad_decoder`.

## Test plan
All scenarios use SAMPLE_DIV = 2, DEBOUNCE_CNT = 3, FIFO_DEPTH = 4.
- **Single press:** drive bit4 (key 5) for 10 ticks, then 0, with `out_ready` = 1 → exactly one handshake with `out_code` = 0x5. `key_held` is high between the press and the release.
- **Bounce:** bit9 for 1 tick, 0 for 1 tick, then bit9 for 5 ticks → exactly one 0xA event. `out_valid` rises on the clock after the push on the 3rd consecutive bit9 sample.
- **Release glitch:** hold bit11, drop it to 0 for 2 ticks, restore it for 5 ticks, then 0 → exactly one 0xB event.
- **Overflow:** `out_ready` = 0, five distinct debounced presses (1, 2, 3, 4, 0) → FIFO holds 1, 2, 3, 4 and `err_ovf` = 1. Draining afterwards yields 1, 2, 3, 4 in order.
- **Full FIFO with same-cycle pop:** fill the FIFO with 4 codes and hold `out_ready` = 0. Set `out_ready` = 1 for exactly the cycle in which the 5th code is pushed → that handshake pops the 1st code and the 5th code is accepted. `err_ovf` stays 0, and subsequent draining yields codes 2..5 in order.
- **Invalid sample and reset:** drive bit0 | bit1 for 5 ticks → no event and `err_multi` = 1. Then assert `rst` mid-press of key 7 → all outputs return to their reset values. Hold key 7 for 3 more ticks after reset → one 0x7 event.
